// File: rtl/regfile_wb_sched_if.sv
// Bundles the write-back requester, issue/scoreboard-query and register-file
// write-port signals of regfile_wb_sched.
interface regfile_wb_sched_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    // Requester handshake: a write transfers on a cycle where valid && ready.
    // While valid and not ready, the requester holds addr/data stable.
    logic             req0_valid;
    logic [AW-1:0]    req0_addr;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [AW-1:0]    req1_addr;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;

    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic [AW-1:0]    chk_addr0;
    logic [AW-1:0]    chk_addr1;
    logic             chk_busy0;
    logic             chk_busy1;

    logic             we0;
    logic [AW-1:0]    wr_addr0;
    logic [WIDTH-1:0] wr_din0;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output iss_valid, iss_addr, chk_addr0, chk_addr1,
        input  chk_busy0, chk_busy1,
        input  we0, wr_addr0, wr_din0
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  iss_valid, iss_addr, chk_addr0, chk_addr1,
        output chk_busy0, chk_busy1,
        output we0, wr_addr0, wr_din0
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin write-back scheduler for the register-file write port, with a
// registered output stage and a per-register busy scoreboard.
module regfile_wb_sched #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_sched_if.slave  wb
);
    localparam int AW = $clog2(DEPTH);

    logic             r_prio;
    logic             r_we0;
    logic [AW-1:0]    r_wr_addr0;
    logic [WIDTH-1:0] r_wr_din0;
    logic [DEPTH-1:0] r_busy;

    logic [1:0]       w_grant;
    logic             w_hs;
    logic [AW-1:0]    w_sel_addr;
    logic [WIDTH-1:0] w_sel_data;
    logic [DEPTH-1:0] w_busy_nxt;

    // r_prio names the requester that wins when both are valid.
    always_comb begin
        w_grant = 2'b00;
        if (wb.req0_valid && wb.req1_valid) begin
            w_grant = r_prio ? 2'b10 : 2'b01;
        end else begin
            w_grant = {wb.req1_valid, wb.req0_valid};
        end
    end

    assign wb.req0_ready = w_grant[0];
    assign wb.req1_ready = w_grant[1];
    assign w_hs          = |w_grant;
    assign w_sel_addr    = w_grant[1] ? wb.req1_addr : wb.req0_addr;
    assign w_sel_data    = w_grant[1] ? wb.req1_data : wb.req0_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio <= 1'b0;
        end else if (w_hs) begin
            r_prio <= w_grant[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we0      <= 1'b0;
            r_wr_addr0 <= '0;
            r_wr_din0  <= '0;
        end else if (w_hs) begin
            r_we0      <= (w_sel_addr != '0);
            r_wr_addr0 <= w_sel_addr;
            r_wr_din0  <= w_sel_data;
        end else begin
            r_we0      <= 1'b0;
        end
    end

    // Clear first so that a same-edge set for a new producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we0) begin
            w_busy_nxt[r_wr_addr0] = 1'b0;
        end
        if (wb.iss_valid) begin
            w_busy_nxt[wb.iss_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign wb.chk_busy0 = r_busy[wb.chk_addr0];
    assign wb.chk_busy1 = r_busy[wb.chk_addr1];
    assign wb.we0       = r_we0;
    assign wb.wr_addr0  = r_wr_addr0;
    assign wb.wr_din0   = r_wr_din0;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios plus random traffic, checked
// against a transaction-level model and an expected-write queue.
module tb_regfile_wb_sched;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic clk;
    logic rst;

    regfile_wb_sched_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    regfile_wb_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int                      n_checks;
    int                      n_errors;
    bit                      m_prio;
    bit                      m_busy [DEPTH];
    bit                      m_we;
    logic [AW-1:0]           m_waddr;
    logic [WIDTH-1:0]        m_wdin;
    logic [AW+WIDTH-1:0]     exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prio  = 1'b0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdin  = '0;
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        exp_q.delete();
    endtask

    // -1: no grant, otherwise the requester that wins this cycle.
    function automatic int model_grant();
        if (bus.req0_valid && bus.req1_valid) return m_prio ? 1 : 0;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_step(input int g);
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_we) m_busy[m_waddr] = 1'b0;
        if (bus.iss_valid && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
        if (g >= 0) begin
            a       = (g == 1) ? bus.req1_addr : bus.req0_addr;
            d       = (g == 1) ? bus.req1_data : bus.req0_data;
            m_we    = (a != 0);
            m_waddr = a;
            m_wdin  = d;
            m_prio  = (g == 0);
            if (a != 0) exp_q.push_back({a, d});
        end else begin
            m_we = 1'b0;
        end
    endtask

    // Entered at posedge+1 with inputs driven; checks mid-cycle, then
    // advances model and DUT across one rising edge.
    task automatic cycle();
        int                  g;
        logic [AW+WIDTH-1:0] e;
        #3;
        g = model_grant();
        check("ready0", bus.req0_ready, g == 0);
        check("ready1", bus.req1_ready, g == 1);
        check("we0", bus.we0, m_we);
        check("wr_addr0", bus.wr_addr0, m_waddr);
        check("wr_din0", bus.wr_din0, m_wdin);
        check("chk_busy0", bus.chk_busy0, m_busy[bus.chk_addr0]);
        check("chk_busy1", bus.chk_busy1, m_busy[bus.chk_addr1]);
        if (bus.we0 === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("write_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("write_stream", {bus.wr_addr0, bus.wr_din0}, e);
            end
        end
        @(posedge clk);
        model_step(g);
        #1;
    endtask

    // Driver tasks
    task automatic drive_req(input logic v0, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                             input logic v1, input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    endtask

    task automatic drive_iss(input logic v, input logic [AW-1:0] a);
        bus.iss_valid = v;
        bus.iss_addr  = a;
    endtask

    task automatic idle();
        drive_req(1'b0, '0, '0, 1'b0, '0, '0);
        drive_iss(1'b0, '0);
    endtask

    initial begin
        int g;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst = 1'b0;
        idle();
        bus.chk_addr0 = 5'd3;
        bus.chk_addr1 = 5'd4;

        // Reset: requests are acknowledged but produce no write.
        @(posedge clk); #1;
        drive_req(1'b1, 5'd4, 32'h1111_2222, 1'b1, 5'd3, 32'h3333_4444);
        drive_iss(1'b1, 5'd3);
        repeat (3) cycle();
        check("rst_we0", bus.we0, 1'b0);
        check("rst_wr_addr0", bus.wr_addr0, '0);
        check("rst_wr_din0", bus.wr_din0, '0);
        check("rst_busy", bus.chk_busy0, 1'b0);

        rst = 1'b1;
        drive_req(1'b0, 5'd4, 32'h1111_2222, 1'b1, 5'd3, 32'h3333_4444);
        drive_iss(1'b0, '0);
        cycle();
        idle();
        check("rel_we0", bus.we0, 1'b1);
        check("rel_wr_addr0", bus.wr_addr0, 5'd3);

        // Contention: grants alternate starting with requester 0.
        for (int k = 0; k < 4; k++) begin
            drive_req(1'b1, 5'd1, 32'hA000_0000 + k, 1'b1, 5'd2, 32'hB000_0000 + k);
            #3;
            check("cont_ready0", bus.req0_ready, (k % 2) == 0);
            #(-0);
            @(posedge clk); model_step(model_grant()); #1;
            check("cont_we0", bus.we0, 1'b1);
            check("cont_addr", bus.wr_addr0, (k % 2) == 0 ? 5'd1 : 5'd2);
            void'(exp_q.pop_front());
        end
        drive_req(1'b0, '0, '0, 1'b1, 5'd6, 32'h0606_0606);
        cycle();
        check("only1_addr", bus.wr_addr0, 5'd6);

        // Single write with hold afterwards.
        drive_req(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
        cycle();
        idle();
        check("single_we0", bus.we0, 1'b1);
        check("single_din", bus.wr_din0, 32'hDEAD_BEEF);
        cycle();
        check("single_drop", bus.we0, 1'b0);
        check("single_hold", bus.wr_din0, 32'hDEAD_BEEF);

        // x0 write and x0 issue.
        bus.chk_addr1 = 5'd0;
        drive_req(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
        drive_iss(1'b1, 5'd0);
        cycle();
        idle();
        check("x0_we0", bus.we0, 1'b0);
        check("x0_busy", bus.chk_busy1, 1'b0);
        cycle();

        // Scoreboard set then clear.
        bus.chk_addr0 = 5'd7;
        drive_iss(1'b1, 5'd7);
        cycle();
        idle();
        check("sb_set", bus.chk_busy0, 1'b1);
        drive_req(1'b1, 5'd7, 32'h0000_0007, 1'b0, '0, '0);
        cycle();
        idle();
        check("sb_m1", bus.chk_busy0, 1'b1);
        cycle();
        check("sb_m2", bus.chk_busy0, 1'b0);

        // Set/clear collision on register 9.
        bus.chk_addr0 = 5'd9;
        drive_req(1'b1, 5'd9, 32'h0000_0009, 1'b0, '0, '0);
        cycle();
        idle();
        drive_iss(1'b1, 5'd9);
        cycle();
        idle();
        check("collide_busy", bus.chk_busy0, 1'b1);
        cycle();

        // Mid-operation asynchronous reset.
        bus.chk_addr1 = 5'd11;
        drive_iss(1'b1, 5'd11);
        cycle();
        drive_iss(1'b0, '0);
        drive_req(1'b1, 5'd11, 32'h0B0B_0B0B, 1'b0, '0, '0);
        cycle();
        idle();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_we0", bus.we0, 1'b0);
        check("arst_busy9", bus.chk_busy0, 1'b0);
        check("arst_busy11", bus.chk_busy1, 1'b0);
        @(posedge clk); #1;
        cycle();
        rst = 1'b1;
        cycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if (!(bus.req0_valid && g != 0) || n == 0) begin
                bus.req0_valid = ($urandom_range(0, 3) != 0);
                bus.req0_addr  = AW'($urandom_range(0, DEPTH - 1));
                bus.req0_data  = $urandom;
            end
            if (!(bus.req1_valid && g != 1) || n == 0) begin
                bus.req1_valid = ($urandom_range(0, 2) != 0);
                bus.req1_addr  = AW'($urandom_range(0, DEPTH - 1));
                bus.req1_data  = $urandom;
            end
            drive_iss($urandom_range(0, 1) == 1, AW'($urandom_range(0, DEPTH - 1)));
            bus.chk_addr0 = ($urandom_range(0, 1) == 1) ? m_waddr : AW'($urandom_range(0, DEPTH - 1));
            bus.chk_addr1 = AW'($urandom_range(0, DEPTH - 1));
            g = model_grant();
            cycle();
        end

        idle();
        repeat (3) cycle();
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
